mem_sequencer: RTL and testbench
================================

MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL set the maximum number of cycles waiting for bus_ack (1..255).
REQ-002 cclk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be the reset, asynchronous and active-high.
REQ-004 MemRead, MemWrite, IrWrite  in  1 each  SHALL be the memory strobes from the control unit.
REQ-005 Addr  in  32  SHALL be the byte address (PC or ALUOut, already muxed by IorD).
REQ-006 WrData  in  32  SHALL be the store data (register B).
REQ-007 Stall  out  1  SHALL freeze the control unit state register while high.
REQ-008 Instr  out  32  SHALL be the instruction register; MemData  out  32  SHALL be the memory data register.
REQ-009 bus_req, bus_we  out  1; bus_addr, bus_wdata  out  32; bus_rdata  in  32; bus_ack, bus_err  in  1  SHALL form the external memory bus.
REQ-010 Err  out  1  SHALL be a sticky error flag.

Function
REQ-011 The block SHALL use FSM states IDLE, REQ and DONE.
REQ-012 In IDLE with exactly one of MemRead/MemWrite high and Addr[1:0]==0: latch Addr, WrData, MemWrite and IrWrite; go to REQ.
REQ-013 Stall SHALL equal (IDLE & (MemRead|MemWrite)) | REQ, combinational, so the strobe cycle is stalled immediately.
REQ-014 bus_req SHALL be 1 exactly while in REQ; bus_we, bus_addr and bus_wdata SHALL be driven from the latched values and stay stable throughout REQ.
REQ-015 In REQ, bus_ack=1 and bus_err=0 on a read: load bus_rdata into MemData; also into Instr if the latched IrWrite=1; go to DONE.
REQ-016 In REQ, bus_ack=1 and bus_err=0 on a write: go to DONE with no register update.
REQ-017 In REQ, bus_ack=1 and bus_err=1: set Err, leave Instr/MemData unchanged, go to DONE.
REQ-018 In DONE: Stall=0 for exactly one cycle; strobes SHALL be ignored; next state IDLE. This prevents re-issue while the control unit advances.
REQ-019 In IDLE with MemRead and MemWrite both high, or with Addr[1:0]!=0: set Err, issue no bus request, go to DONE.
REQ-020 bus_ack or bus_err outside REQ SHALL be ignored.
REQ-021 Minimum latency SHALL be strobe cycle to DONE in 2 cycles with same-cycle ack; each bus wait cycle adds 1.
REQ-022 Err SHALL clear only on rst.

Reset
REQ-023 On rst: state IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, Instr=0, MemData=0, Err=0; Stall follows REQ-013.
REQ-024 rst asserted during REQ SHALL drop bus_req asynchronously; the in-flight access SHALL be abandoned with no register update.

Configuration
REQ-025 With MEM_TIMEOUT_EN defined: a wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack. On reaching TIMEOUT_CYCLES it SHALL set Err and go to DONE with no register update.
REQ-026 Without MEM_TIMEOUT_EN: REQ SHALL wait indefinitely, and no counter logic SHALL be present.

Structure
REQ-027 FSM state encodings and the default TIMEOUT_CYCLES SHALL live in the shared package mips_pkg.
REQ-028 The timeout counter SHALL be the sub-module wait_timer (clear, enable, expired), instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-029 Fetch: MemRead=1, IrWrite=1, Addr=0x00000010, bus_ack on 1st REQ cycle with rdata=0x8C220004 -> Instr=MemData=0x8C220004, Stall high 2 cycles, Err=0.
REQ-030 Store: MemWrite=1, Addr=0x00000100, WrData=0xCAFEF00D, ack after 3 wait cycles -> bus_we=1 and bus_addr/bus_wdata stable for 4 REQ cycles, MemData unchanged.
REQ-031 Misaligned: MemRead=1, Addr=0x00000102 -> bus_req never asserted, Err=1, DONE next cycle.
REQ-032 Bus error: read with bus_ack=bus_err=1, rdata=0x12345678 -> MemData keeps its prior value, Err=1 until rst.
REQ-033 Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4): read with no ack -> Err=1 after 4 REQ cycles, then DONE then IDLE.
REQ-034 Reset mid-REQ: rst pulse during wait -> bus_req=0 in the same cycle, Instr=MemData=0, state IDLE, a late bus_ack is ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the multicycle MIPS memory path: sequencer FSM encoding and timeout defaults.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } mseq_state_t;

    localparam int DEF_TIMEOUT_CYCLES = 64;
    localparam int TMO_CNT_W          = 8;

endpackage

// File: rtl/wait_timer.sv
// Bus wait counter: expired is asserted on the LIMIT-th consecutive enabled cycle after a clear.
// Latency: combinational expired from the registered count; no backpressure.
module wait_timer
    import mips_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
    input  logic cclk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMO_CNT_W-1:0] cnt;

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + TMO_CNT_W'(1);
        end
    end

    // Fires during the last allowed wait cycle so the FSM leaves REQ on that edge.
    assign expired = enable && (cnt == TMO_CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_sequencer.sv
// Memory sequencer between the multicycle control unit and an ack-based memory bus (IDLE/REQ/DONE).
// Latency: strobe cycle -> DONE in 2 cycles with same-cycle ack, +1 per bus wait cycle.
// Backpressure: Stall holds the control unit until DONE; optional REQ timeout under MEM_TIMEOUT_EN.
module mem_sequencer
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        cclk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        IrWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic        Stall,
    output logic [31:0] Instr,
    output logic [31:0] MemData,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    output logic        Err
);

    mseq_state_t state;
    logic        lat_ir;
    logic        tmo_expired;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_sequencer: TIMEOUT_CYCLES must be 1..255");
    end

`ifdef MEM_TIMEOUT_EN
    wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .cclk   (cclk),
        .rst    (rst),
        .clear  (state != ST_REQ),
        .enable ((state == ST_REQ) && !bus_ack),
        .expired(tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    // Combinational so the strobe cycle itself is already frozen.
    assign Stall = ((state == ST_IDLE) && (MemRead || MemWrite)) || (state == ST_REQ);

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            lat_ir    <= 1'b0;
            Instr     <= '0;
            MemData   <= '0;
            Err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (MemRead && MemWrite) begin
                        Err   <= 1'b1;
                        state <= ST_DONE;
                    end else if (MemRead || MemWrite) begin
                        if (Addr[1:0] == 2'b00) begin
                            bus_addr  <= Addr;
                            bus_wdata <= WrData;
                            bus_we    <= MemWrite;
                            lat_ir    <= IrWrite;
                            bus_req   <= 1'b1;
                            state     <= ST_REQ;
                        end else begin
                            Err   <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= ST_DONE;
                        if (bus_err) begin
                            Err <= 1'b1;
                        end else if (!bus_we) begin
                            MemData <= bus_rdata;
                            if (lat_ir) begin
                                Instr <= bus_rdata;
                            end
                        end
                    end else if (tmo_expired) begin
                        Err     <= 1'b1;
                        bus_req <= 1'b0;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    bus_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer; covers the timeout path when built with MEM_TIMEOUT_EN.
module tb_mem_sequencer;

    logic        cclk;
    logic        rst;
    logic        MemRead, MemWrite, IrWrite;
    logic [31:0] Addr, WrData;
    logic        Stall;
    logic [31:0] Instr, MemData;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ack, bus_err;
    logic        Err;

    int total = 0;
    int bad   = 0;

    mem_sequencer #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .cclk     (cclk),
        .rst      (rst),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .IrWrite  (IrWrite),
        .Addr     (Addr),
        .WrData   (WrData),
        .Stall    (Stall),
        .Instr    (Instr),
        .MemData  (MemData),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack),
        .bus_err  (bus_err),
        .Err      (Err)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge cclk);
        #2;
    endtask

    task automatic idle_inputs();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IrWrite  = 1'b0;
        bus_ack  = 1'b0;
        bus_err  = 1'b0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        Addr      = '0;
        WrData    = '0;
        bus_rdata = '0;
        #1;
        // Reset state
        chk("rst_bus_req",   bus_req,   0);
        chk("rst_bus_we",    bus_we,    0);
        chk("rst_bus_addr",  bus_addr,  0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_instr",     Instr,     0);
        chk("rst_memdata",   MemData,   0);
        chk("rst_err",       Err,       0);
        chk("rst_stall0",    Stall,     0);
        MemRead = 1'b1;
        #1;
        chk("rst_stall_follows_strobe", Stall, 1);
        MemRead = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Fetch with same-cycle ack
        MemRead = 1'b1; IrWrite = 1'b1; Addr = 32'h0000_0010;
        #1;
        chk("fetch_stall_strobe", Stall, 1);
        chk("fetch_no_req_yet", bus_req, 0);
        step();
        bus_ack = 1'b1; bus_rdata = 32'h8C22_0004;
        #1;
        chk("fetch_req", bus_req, 1);
        chk("fetch_addr", bus_addr, 32'h0000_0010);
        chk("fetch_we", bus_we, 0);
        chk("fetch_stall_req", Stall, 1);
        step();
        bus_ack = 1'b0;
        #1;
        chk("fetch_done_stall", Stall, 0);
        chk("fetch_done_req", bus_req, 0);
        chk("fetch_instr", Instr, 32'h8C22_0004);
        chk("fetch_memdata", MemData, 32'h8C22_0004);
        chk("fetch_err", Err, 0);
        idle_inputs();
        step();
        chk("fetch_idle_stall", Stall, 0);

        // Store with 3 wait cycles; inputs change after launch to prove latching
        MemWrite = 1'b1; Addr = 32'h0000_0100; WrData = 32'hCAFE_F00D;
        step();
        Addr = 32'hDEAD_BEEC; WrData = 32'h0BAD_0BAD; bus_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus_ack = 1'b1;
            #1;
            chk("store_req", bus_req, 1);
            chk("store_we", bus_we, 1);
            chk("store_addr", bus_addr, 32'h0000_0100);
            chk("store_wdata", bus_wdata, 32'hCAFE_F00D);
            chk("store_stall", Stall, 1);
            step();
        end
        bus_ack = 1'b0;
        #1;
        chk("store_done_stall", Stall, 0);
        chk("store_done_req", bus_req, 0);
        chk("store_memdata_kept", MemData, 32'h8C22_0004);
        chk("store_instr_kept", Instr, 32'h8C22_0004);
        idle_inputs();
        step();

        // Stray ack in IDLE is ignored
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        step();
        bus_ack = 1'b0;
        #1;
        chk("stray_ack_memdata", MemData, 32'h8C22_0004);
        chk("stray_ack_req", bus_req, 0);
        chk("stray_ack_err", Err, 0);

        // Misaligned read
        MemRead = 1'b1; Addr = 32'h0000_0102;
        #1;
        chk("misal_stall", Stall, 1);
        step();
        #1;
        chk("misal_req", bus_req, 0);
        chk("misal_err", Err, 1);
        chk("misal_done_stall", Stall, 0);
        idle_inputs();
        step();
        chk("misal_idle_req", bus_req, 0);

        // Both strobes high
        pulse_reset();
        chk("both_err_cleared", Err, 0);
        MemRead = 1'b1; MemWrite = 1'b1; Addr = 32'h0000_0020;
        step();
        #1;
        chk("both_req", bus_req, 0);
        chk("both_err", Err, 1);
        chk("both_done_stall", Stall, 0);
        idle_inputs();
        step();

        // Bus error after priming MemData with a good read
        pulse_reset();
        MemRead = 1'b1; Addr = 32'h0000_0040;
        step();
        bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
        step();
        idle_inputs();
        chk("prime_memdata", MemData, 32'h1111_2222);
        chk("prime_instr_untouched", Instr, 0);
        step();
        MemRead = 1'b1; Addr = 32'h0000_0044;
        step();
        bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h1234_5678;
        step();
        idle_inputs();
        chk("buserr_memdata", MemData, 32'h1111_2222);
        chk("buserr_err", Err, 1);
        chk("buserr_req", bus_req, 0);
        for (int i = 0; i < 3; i++) step();
        chk("buserr_err_sticky", Err, 1);

`ifdef MEM_TIMEOUT_EN
        pulse_reset();
        MemRead = 1'b1; Addr = 32'h0000_0080;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("tmo_req_wait", bus_req, 1);
            chk("tmo_err_wait", Err, 0);
            step();
        end
        chk("tmo_err", Err, 1);
        chk("tmo_done_req", bus_req, 0);
        chk("tmo_done_stall", Stall, 0);
        idle_inputs();
        step();
        chk("tmo_idle_stall", Stall, 0);
        chk("tmo_memdata", MemData, 0);
        MemRead = 1'b1; Addr = 32'h0000_0084;
        step();
        step();
`else
        pulse_reset();
        MemRead = 1'b1; Addr = 32'h0000_0080;
        step();
        for (int i = 0; i < 10; i++) step();
        chk("nowait_req_held", bus_req, 1);
        chk("nowait_stall_held", Stall, 1);
        chk("nowait_err", Err, 0);
`endif

        // Reset mid-REQ: prime MemData first is not possible without ack; check abandonment instead
        chk("midrst_req_before", bus_req, 1);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("midrst_req_async", bus_req, 0);
        chk("midrst_instr", Instr, 0);
        chk("midrst_memdata", MemData, 0);
        rst = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'hAAAA_5555;
        step();
        bus_ack = 1'b0;
        #1;
        chk("midrst_late_ack_memdata", MemData, 0);
        chk("midrst_late_ack_req", bus_req, 0);
        chk("midrst_idle_stall", Stall, 0);
        MemRead = 1'b1; Addr = 32'h0000_0090;
        #1;
        chk("midrst_idle_accepts", Stall, 1);
        step();
        chk("midrst_new_req", bus_req, 1);
        chk("midrst_new_addr", bus_addr, 32'h0000_0090);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
